// File: rtl/ecc_encoder.sv
// Two-stage Hamming(38,32) encoder with a valid/ready stream interface and a
// one-shot fault injector that flips a single chosen codeword bit.
module ecc_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_parity,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        inj_req,
  input  logic [5:0]  inj_pos,
  output logic        inj_err,
  output logic        out_injected,
  output logic [15:0] out_count
);

  logic        r_s1Valid;
  logic [31:0] r_s1Data;
  logic        r_s2Valid;
  logic [31:0] r_s2Data;
  logic [5:0]  r_s2Parity;
  logic        r_s2Injected;
  logic        r_armed;
  logic [5:0]  r_injPos;
  logic        r_injErr;
  logic [15:0] r_count;

  logic        w_s2Load;
  logic        w_injPosOk;
  logic [38:1] w_code;
  logic [5:0]  w_parity;
  logic [5:0]  w_pos;
  logic [31:0] w_encData;
  logic [5:0]  w_encParity;

  // Codeword position of data bit k: the (k+1)-th position that is not a power of two.
  function automatic logic [5:0] dataPos(input int k);
    int          cnt;
    logic [5:0]  pos;
    cnt = 0;
    pos = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = 6'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  assign w_s2Load   = !r_s2Valid || out_ready;
  assign in_ready   = !r_s1Valid || w_s2Load;
  assign w_injPosOk = (inj_pos != 6'd0) && (inj_pos <= 6'd38);

  // Parity is always formed on clean data; the injected flip is applied to the finished codeword.
  always_comb begin
    w_code      = '0;
    w_parity    = '0;
    w_pos       = '0;
    w_encData   = '0;
    w_encParity = '0;
    for (int k = 0; k < 32; k++) begin
      w_pos = dataPos(k);
      w_code[w_pos] = r_s1Data[5'(k)];
      for (int i = 0; i < 6; i++) begin
        if (w_pos[3'(i)]) w_parity[3'(i)] = w_parity[3'(i)] ^ r_s1Data[5'(k)];
      end
    end
    for (int i = 0; i < 6; i++) begin
      w_code[6'(1 << i)] = w_parity[3'(i)];
    end
    if (r_armed) w_code[r_injPos] = ~w_code[r_injPos];
    for (int k = 0; k < 32; k++) begin
      w_encData[5'(k)] = w_code[dataPos(k)];
    end
    for (int i = 0; i < 6; i++) begin
      w_encParity[3'(i)] = w_code[6'(1 << i)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid    <= 1'b0;
      r_s1Data     <= '0;
      r_s2Valid    <= 1'b0;
      r_s2Data     <= '0;
      r_s2Parity   <= '0;
      r_s2Injected <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1Valid <= in_valid;
        if (in_valid) r_s1Data <= in_data;
      end
      if (w_s2Load) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_s2Data     <= w_encData;
          r_s2Parity   <= w_encParity;
          r_s2Injected <= r_armed;
        end
      end
    end
  end

  // A fresh arm wins over the clear, so a request landing on an S2 load targets the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed  <= 1'b0;
      r_injPos <= '0;
      r_injErr <= 1'b0;
    end else begin
      r_injErr <= inj_req && !w_injPosOk;
      if (inj_req && w_injPosOk) begin
        r_armed  <= 1'b1;
        r_injPos <= inj_pos;
      end else if (w_s2Load && r_s1Valid) begin
        r_armed  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_s2Valid && out_ready && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign out_valid    = r_s2Valid;
  assign out_data     = r_s2Data;
  assign out_parity   = r_s2Parity;
  assign out_injected = r_s2Injected;
  assign inj_err      = r_injErr;
  assign out_count    = r_count;

endmodule
